// File: rtl/eprom_prog_pkg.sv
// Shared types and constants for the EPROM programming controller and its
// companion EPROM array model.
package eprom_prog_pkg;

  localparam int EPROM_ADDR_W = 4;
  localparam int EPROM_DATA_W = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ERASE,
    S_BLANK,
    S_PWAIT,
    S_PULSE,
    S_GAP,
    S_VERIFY,
    S_CHECK,
    S_FIN
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_BLANK  = 2'd1;
  localparam logic [1:0] ERR_VERIFY = 2'd2;
  localparam logic [1:0] ERR_ABORT  = 2'd3;

endpackage

// File: rtl/eprom_pgm_timer.sv
// Loadable down-counter that times the programming pulse; 'last' is high in
// the final cycle of a CYCLES-long pulse that started with a load.
module eprom_pgm_timer #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(CYCLES - 1);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/eprom_programmer.sv
// Programming-session controller for an asynchronous-read EPROM array:
// erase, blank check, streamed word programming and checksum verify.
module eprom_programmer
  import eprom_prog_pkg::*;
#(
  parameter int ADDR_W     = EPROM_ADDR_W,
  parameter int DATA_W     = EPROM_DATA_W,
  parameter int PGM_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_erase,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wreg;
  logic [DATA_W-1:0]   sum_w;
  logic [DATA_W-1:0]   sum_r;
  logic                at_last;
  logic                in_session;
  logic                abort_hit;
  logic                pulse_last;

  assign at_last    = (addr == '1);
  assign in_session = (state != S_IDLE) && (state != S_FIN);
  assign abort_hit  = abort && in_session;

  eprom_pgm_timer #(.CYCLES(PGM_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state == S_PWAIT && in_valid),
    .en   (state == S_PULSE),
    .last (pulse_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_ERASE;
      S_ERASE:  state_nx = S_BLANK;
      S_BLANK:  if (mem_rdata != '0) state_nx = S_FIN;
                else if (at_last)    state_nx = S_PWAIT;
      S_PWAIT:  if (in_valid) state_nx = S_PULSE;
      S_PULSE:  if (pulse_last) state_nx = S_GAP;
      S_GAP:    state_nx = at_last ? S_VERIFY : S_PWAIT;
      S_VERIFY: if (at_last) state_nx = S_CHECK;
      S_CHECK:  state_nx = S_FIN;
      S_FIN:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    // Abort wins over every other transition, including a pending handshake.
    if (abort_hit) state_nx = S_FIN;
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    busy      = in_session;
    in_ready  = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_erase = 1'b0;
    case (state)
      S_ERASE: mem_erase = 1'b1;
      S_PWAIT: in_ready  = 1'b1;
      S_PULSE: mem_we    = 1'b1;
      S_FIN:   done      = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = addr;
  assign mem_wdata = wreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      wreg      <= '0;
      sum_w     <= '0;
      sum_r     <= '0;
      pass      <= 1'b0;
      err_code  <= ERR_NONE;
      fail_addr <= '0;
    end else if (abort_hit) begin
      pass     <= 1'b0;
      err_code <= ERR_ABORT;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          addr      <= '0;
          sum_w     <= '0;
          sum_r     <= '0;
          pass      <= 1'b0;
          err_code  <= ERR_NONE;
          fail_addr <= '0;
        end
        S_BLANK: begin
          if (mem_rdata != '0) begin
            err_code  <= ERR_BLANK;
            fail_addr <= addr;
          end else begin
            addr <= at_last ? '0 : addr + 1'b1;
          end
        end
        S_PWAIT: if (in_valid) begin
          wreg  <= in_data;
          sum_w <= sum_w + in_data;
        end
        S_GAP: addr <= at_last ? '0 : addr + 1'b1;
        S_VERIFY: begin
          sum_r <= sum_r + mem_rdata;
          addr  <= at_last ? '0 : addr + 1'b1;
        end
        S_CHECK: begin
          if (sum_r == sum_w) begin
            pass     <= 1'b1;
            err_code <= ERR_NONE;
          end else begin
            err_code <= ERR_VERIFY;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
